// File: rtl/event_irq_ctrl.sv
// ---------------------------------------------------------------------------
// event_irq_ctrl
//
// Per-core interrupt/event collector in front of the sleep controller.
// 32 interrupt lines and 32 event lines are rising-edge detected into
// pending registers. APB-programmable masks gate the pending bits onto
// the irq_o / event_o wake-up pair. The lowest-index enabled pending
// interrupt is presented on irq_id_o and is cleared by irq_ack_i.
//
// APB handshake: a transfer's access phase is PSEL & PENABLE. PREADY is
// always 1, so every access completes in that cycle. Writes commit on the
// clock edge that ends the access phase. Read data is combinational
// during the access phase and 0 at all other times.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   PADDR, PWDATA,       APB slave; PADDR[4:2] selects one of 8 words,
//   PWRITE, PSEL,        and addresses above 0x1C read 0 and ignore
//   PENABLE              writes
//   PRDATA, PREADY,      APB response (PREADY=1, PSLVERR=0)
//   PSLVERR
//   irq_lines_i          interrupt sources, active-high, HCLK domain
//   event_lines_i        event sources, active-high, HCLK domain
//   irq_ack_i            single-cycle acknowledge of irq_id_o
//   irq_o                any enabled interrupt pending
//   irq_id_o             lowest-index enabled pending interrupt (0 if none)
//   event_o              any enabled event pending
//
// Register map (word offsets)
//   0x00 IRQ_MASK R/W   0x04 IRQ_PEND RO   0x08 IRQ_SET W1S   0x0C IRQ_CLR W1C
//   0x10 EVT_MASK R/W   0x14 EVT_PEND RO   0x18 EVT_SET W1S   0x1C EVT_CLR W1C
//
// APB_ADDR_WIDTH must be at least 6 because address bits above bit 4 are
// decoded.
// ---------------------------------------------------------------------------
module event_irq_ctrl #(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [31:0]               irq_lines_i,
    input  logic [31:0]               event_lines_i,
    input  logic                      irq_ack_i,
    output logic                      irq_o,
    output logic [4:0]                irq_id_o,
    output logic                      event_o
);

    localparam logic [2:0] REG_IRQ_MASK = 3'd0;
    localparam logic [2:0] REG_IRQ_PEND = 3'd1;
    localparam logic [2:0] REG_IRQ_SET  = 3'd2;
    localparam logic [2:0] REG_IRQ_CLR  = 3'd3;
    localparam logic [2:0] REG_EVT_MASK = 3'd4;
    localparam logic [2:0] REG_EVT_PEND = 3'd5;
    localparam logic [2:0] REG_EVT_SET  = 3'd6;
    localparam logic [2:0] REG_EVT_CLR  = 3'd7;

    logic [31:0] irq_mask;
    logic [31:0] irq_pend;
    logic [31:0] evt_mask;
    logic [31:0] evt_pend;
    logic [31:0] irq_prev;
    logic [31:0] evt_prev;

    logic        addr_hit;
    logic [2:0]  reg_sel;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] irq_rise;
    logic [31:0] evt_rise;
    logic [31:0] irq_set;
    logic [31:0] irq_clr;
    logic [31:0] evt_set;
    logic [31:0] evt_clr;
    logic [31:0] irq_ack_clr;
    logic [31:0] irq_active;

    // Byte-lane bits carry no meaning in a word-only register file.
    logic unused_paddr;
    assign unused_paddr = ^PADDR[1:0];

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    // Only the first 32 bytes are mapped; higher words must not alias.
    assign addr_hit = (PADDR[APB_ADDR_WIDTH-1:5] == '0);
    assign reg_sel  = PADDR[4:2];
    assign wr_en    = PSEL & PENABLE & PWRITE & addr_hit;
    assign rd_en    = PSEL & PENABLE & ~PWRITE & addr_hit;

    assign irq_rise = irq_lines_i & ~irq_prev;
    assign evt_rise = event_lines_i & ~evt_prev;

    assign irq_set = (wr_en && reg_sel == REG_IRQ_SET) ? PWDATA : '0;
    assign irq_clr = (wr_en && reg_sel == REG_IRQ_CLR) ? PWDATA : '0;
    assign evt_set = (wr_en && reg_sel == REG_EVT_SET) ? PWDATA : '0;
    assign evt_clr = (wr_en && reg_sel == REG_EVT_CLR) ? PWDATA : '0;

    // An acknowledge with nothing enabled pending must not clear bit 0,
    // which is what irq_id_o shows when idle.
    assign irq_ack_clr = (irq_ack_i && irq_o) ? (32'd1 << irq_id_o) : '0;

    assign irq_active = irq_pend & irq_mask;
    assign irq_o      = |irq_active;
    assign event_o    = |(evt_pend & evt_mask);

    // Lowest set bit wins: scanning downward leaves the smallest index.
    always_comb begin
        irq_id_o = '0;
        for (int i = 31; i >= 0; i--) begin
            if (irq_active[i]) begin
                irq_id_o = 5'(i);
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd_en) begin
            case (reg_sel)
                REG_IRQ_MASK: PRDATA = irq_mask;
                REG_IRQ_PEND: PRDATA = irq_pend;
                REG_EVT_MASK: PRDATA = evt_mask;
                REG_EVT_PEND: PRDATA = evt_pend;
                default:      PRDATA = '0;
            endcase
        end
    end

    // Set and rise are OR-ed in after clears so they win on a collision.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_mask <= '0;
            irq_pend <= '0;
            evt_mask <= '0;
            evt_pend <= '0;
            irq_prev <= '0;
            evt_prev <= '0;
        end else begin
            irq_prev <= irq_lines_i;
            evt_prev <= event_lines_i;
            irq_pend <= (irq_pend & ~irq_clr & ~irq_ack_clr) | irq_rise | irq_set;
            evt_pend <= (evt_pend & ~evt_clr) | evt_rise | evt_set;
            if (wr_en && reg_sel == REG_IRQ_MASK) begin
                irq_mask <= PWDATA;
            end
            if (wr_en && reg_sel == REG_EVT_MASK) begin
                evt_mask <= PWDATA;
            end
        end
    end

endmodule
